// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU:
//   - 4-bit opcode constants
//   - bit positions inside the 5-bit flags vector {illegal, overflow, carry,
//     negative, zero}
//   - control state encoding used by alu_pipe
//   - helper to classify the iterative (multi-cycle) opcodes
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;

  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_NEGATIVE = 1;
  localparam int FLAG_CARRY    = 2;
  localparam int FLAG_OVERFLOW = 3;
  localparam int FLAG_ILLEGAL  = 4;
  localparam int FLAG_W        = 5;

  // IDLE: output register empty, MUL: multiplier iterating,
  // FULL: output register holds a result waiting for the consumer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  // Both multiply flavours go through the shared iterative multiplier.
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Radix-2 shift-add unsigned multiplier, one partial product per cycle.
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : capture op_a/op_b and begin a new multiplication
//   op_a, op_b : WIDTH-bit unsigned operands
//   busy       : an operation is iterating
//   done       : this cycle performs the final iteration; product is the
//                complete 2*WIDTH-bit result during this cycle
//   product    : full 2*WIDTH-bit product (valid while done=1)
// Timing: start sampled at edge N, iterations on edges N+1 .. N+WIDTH, so a
// consumer registering product while done=1 holds the result after N+WIDTH.
// ---------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     hi_sum;
  logic [CNT_W-1:0]   count_q;

  // One shift-add step. The low half of acc_q starts as the multiplier and
  // is consumed from bit 0 as the partial sums shift in from the top, so
  // after WIDTH steps the register holds the complete product.
  always_comb begin
    hi_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {hi_sum, acc_q[WIDTH-1:1]};
  end

  assign done    = busy && (count_q == CNT_W'(WIDTH - 1));
  assign product = acc_step;

  // Operand capture on start, then one step per cycle until the last
  // iteration; reset drops any multiplication in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      mcand_q <= op_a;
      acc_q   <= {{WIDTH{1'b0}}, op_b};
      count_q <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      acc_q   <= acc_step;
      count_q <= count_q + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
// Single-entry ALU with a valid/ready handshake on both sides. Simple ops
// complete in the accept cycle; MUL/MULHU use the iterative multiplier and
// take WIDTH extra cycles, during which no new request is accepted.
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid / in_ready : request handshake (op_a, op_b, alu_op)
//   out_valid/out_ready : result handshake (result, flags)
//   result              : registered WIDTH-bit result
//   flags               : registered {illegal, overflow, carry, negative, zero}
// ---------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [3:0]        alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [4:0]        flags
);

  localparam int SHW = $clog2(WIDTH);

  state_t               state_q;
  state_t               state_d;
  logic                 accept;
  logic                 is_mul_in;
  logic                 mul_start;
  logic                 mul_busy;
  logic                 mul_done;
  logic                 mulhu_q;
  logic [2*WIDTH-1:0]   mul_product;
  logic [WIDTH-1:0]     mul_result;
  logic [FLAG_W-1:0]    mul_flags;
  logic [WIDTH-1:0]     alu_result;
  logic [FLAG_W-1:0]    alu_flags;
  logic [WIDTH:0]       add_wide;
  logic [WIDTH-1:0]     diff;
  logic [SHW-1:0]       shamt;

  assign is_mul_in = is_mul_op(alu_op);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_FULL);
  assign shamt     = op_b[SHW-1:0];

  // The multiplier is only ever started from IDLE or FULL; the busy term
  // keeps a stray start from corrupting an operation already iterating.
  assign mul_start = accept && is_mul_in && !mul_busy;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath for every non-multiply opcode. Carry on SUB is the
  // unsigned borrow; overflow is the signed overflow of ADD/SUB only.
  // Illegal opcodes report only the illegal flag, so zero stays clear even
  // though the result is 0.
  always_comb begin
    alu_result = '0;
    alu_flags  = '0;
    add_wide   = {1'b0, op_a} + {1'b0, op_b};
    diff       = op_a - op_b;
    case (alu_op)
      OP_ADD: begin
        alu_result              = add_wide[WIDTH-1:0];
        alu_flags[FLAG_CARRY]   = add_wide[WIDTH];
        alu_flags[FLAG_OVERFLOW] = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                   (add_wide[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result              = diff;
        alu_flags[FLAG_CARRY]   = (op_a < op_b);
        alu_flags[FLAG_OVERFLOW] = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                                   (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_SLL:  alu_result = op_a << shamt;
      OP_SRL:  alu_result = op_a >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_MUL, OP_MULHU: alu_result = '0;
      default: alu_flags[FLAG_ILLEGAL] = 1'b1;
    endcase
    if (!alu_flags[FLAG_ILLEGAL]) begin
      alu_flags[FLAG_ZERO]     = (alu_result == '0);
      alu_flags[FLAG_NEGATIVE] = alu_result[WIDTH-1];
    end
  end

  // Multiply results only carry zero/negative; MULHU selects the upper half
  // of the full product.
  always_comb begin
    mul_result = mulhu_q ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];
    mul_flags  = '0;
    mul_flags[FLAG_ZERO]     = (mul_result == '0);
    mul_flags[FLAG_NEGATIVE] = mul_result[WIDTH-1];
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and in_ready. A request can be taken when empty, or when the
  // held result leaves in the same cycle, which gives one result per cycle
  // for back-to-back simple ops.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = is_mul_in ? ST_MUL : ST_FULL;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            state_d = is_mul_in ? ST_MUL : ST_FULL;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register. It only changes when a simple op is accepted or the
  // multiplier finishes, so a held result is stable while the consumer
  // stalls. Accept and mul_done never coincide because in_ready is 0 in MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      flags   <= '0;
      mulhu_q <= 1'b0;
    end else if (accept && !is_mul_in) begin
      result <= alu_result;
      flags  <= alu_flags;
    end else if (accept) begin
      mulhu_q <= (alu_op == OP_MULHU);
    end else if (mul_done) begin
      result <= mul_result;
      flags  <= mul_flags;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
// Scoreboard bench for alu_pipe (WIDTH=32): the driver pushes the expected
// {flags, result} of each accepted request; a monitor pops and compares on
// every output handshake. Directed vectors carry hand-computed expectations,
// random vectors use an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W = 32;

  localparam logic [3:0] ADD   = 4'd0;
  localparam logic [3:0] SUB   = 4'd1;
  localparam logic [3:0] AND_  = 4'd2;
  localparam logic [3:0] OR_   = 4'd3;
  localparam logic [3:0] XOR_  = 4'd4;
  localparam logic [3:0] SLL   = 4'd5;
  localparam logic [3:0] SRL   = 4'd6;
  localparam logic [3:0] SLTU  = 4'd7;
  localparam logic [3:0] SRA   = 4'd8;
  localparam logic [3:0] SLT   = 4'd9;
  localparam logic [3:0] MUL   = 4'd10;
  localparam logic [3:0] MULHU = 4'd11;

  localparam int F_ZERO  = 0;
  localparam int F_NEG   = 1;
  localparam int F_CARRY = 2;
  localparam int F_OVF   = 3;
  localparam int F_ILL   = 4;

  typedef struct packed {
    logic [4:0]   flags;
    logic [W-1:0] result;
  } expect_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic [3:0]    alu_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [4:0]    flags;

  int checkCount = 0;
  int passCount  = 0;
  int cycleCount = 0;
  int readyMode  = 0;
  expect_t expectQ[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Consumer model: 0 = always ready, 1 = stalled, 2 = random back-pressure.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic reportTimeout(input string name);
    checkCount++;
    $display("[TB] FAIL %s: timed out waiting on the DUT", name);
  endtask

  // Reference model from the opcode definitions using wide plain arithmetic.
  function automatic expect_t refModel(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    expect_t     e;
    longint      sa;
    longint      sb;
    longint      s;
    logic [63:0] wide;
    int          sh;
    e    = '0;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sh   = int'(b % W);
    wide = '0;
    s    = 0;
    case (op)
      ADD: begin
        wide = 64'(a) + 64'(b);
        s = sa + sb;
        e.result = W'(wide);
        e.flags[F_CARRY] = wide[W];
        e.flags[F_OVF] = (s != longint'($signed(e.result)));
      end
      SUB: begin
        s = sa - sb;
        e.result = W'(s);
        e.flags[F_CARRY] = (a < b);
        e.flags[F_OVF] = (s != longint'($signed(e.result)));
      end
      AND_:  e.result = a & b;
      OR_:   e.result = a | b;
      XOR_:  e.result = a ^ b;
      SLL:   e.result = W'(64'(a) << sh);
      SRL:   e.result = a >> sh;
      SRA: begin
        s = sa >>> sh;
        e.result = W'(s);
      end
      SLTU:  e.result = (a < b) ? 1 : 0;
      SLT:   e.result = (sa < sb) ? 1 : 0;
      MUL: begin
        wide = 64'(a) * 64'(b);
        e.result = wide[W-1:0];
      end
      MULHU: begin
        wide = 64'(a) * 64'(b);
        e.result = wide[2*W-1:W];
      end
      default: begin
        e.flags[F_ILL] = 1'b1;
        return e;
      end
    endcase
    e.flags[F_ZERO] = (e.result == 0);
    e.flags[F_NEG]  = e.result[W-1];
    return e;
  endfunction

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at posedge+1; holds the request until accepted, pushes the
  // expectation and returns the number of the accept edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input expect_t expResp,
                               output int acceptEdge);
    bit accepted;
    accepted   = 0;
    acceptEdge = -1;
    in_valid = 1'b1;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
    for (int w = 0; w < 200 && !accepted; w++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted   = 1;
        acceptEdge = cycleCount + 1;
        expectQ.push_back(expResp);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) reportTimeout("request_accept");
  endtask

  // Offset 0 means out_valid rose on the accept edge itself.
  task automatic waitValid(input int acceptEdge, output int offset, output int readyHigh);
    offset    = -1;
    readyHigh = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        offset = cycleCount - acceptEdge;
        break;
      end
      if (in_ready) readyHigh++;
    end
    if (offset < 0) reportTimeout("wait_out_valid");
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 500; k++) begin
      if (expectQ.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: every output handshake retires the oldest expectation.
  always @(negedge clk) begin
    expect_t e;
    if (rst_n && out_valid && out_ready) begin
      if (expectQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_output: result 0x%0h flags 0x%0h with empty scoreboard",
                 result, flags);
      end else begin
        e = expectQ.pop_front();
        checkOutput("result", 64'(result), 64'(e.result));
        checkOutput("flags", 64'(flags), 64'(e.flags));
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e1, e2, e3, offset, readyHigh, validSeen;
    logic [3:0] op;
    logic [W-1:0] a, b;

    repeat (2) @(negedge clk);
    checkOutput("reset_state", {out_valid, in_ready, flags, result},
                {1'b0, 1'b1, 5'b00000, 32'h0});
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] directed ADD/SUB/SLT/SLTU");
    applyStimulus(ADD, 32'hFFFF_FFFF, 32'h1, {5'b00101, 32'h0}, e1);
    waitValid(e1, offset, readyHigh);
    checkOutput("add_latency", offset, 0);
    applyStimulus(SUB, 32'h8000_0000, 32'h1, {5'b01000, 32'h7FFF_FFFF}, e1);
    applyStimulus(SLT, 32'hFFFF_FFFF, 32'h1, {5'b00000, 32'h1}, e1);
    applyStimulus(SLTU, 32'hFFFF_FFFF, 32'h1, {5'b00001, 32'h0}, e1);
    drain();

    $display("[TB] directed MUL/MULHU");
    applyStimulus(MUL, 32'h0001_0000, 32'h0001_0000, {5'b00001, 32'h0}, e1);
    waitValid(e1, offset, readyHigh);
    checkOutput("mul_latency", offset, 32);
    checkOutput("mul_in_ready_low", readyHigh, 0);
    applyStimulus(MULHU, 32'h0001_0000, 32'h0001_0000, {5'b00000, 32'h1}, e1);
    waitValid(e1, offset, readyHigh);
    checkOutput("mulhu_latency", offset, 32);
    checkOutput("mulhu_in_ready_low", readyHigh, 0);
    drain();

    $display("[TB] back-to-back stream");
    applyStimulus(ADD, 32'd5, 32'd7, {5'b00000, 32'd12}, e1);
    applyStimulus(XOR_, 32'hF0F0_F0F0, 32'hFF00_FF00, {5'b00000, 32'h0FF0_0FF0}, e2);
    applyStimulus(SRA, 32'h8000_0000, 32'h24, {5'b00010, 32'hF800_0000}, e3);
    checkOutput("throughput_1", e2 - e1, 1);
    checkOutput("throughput_2", e3 - e2, 1);
    drain();

    $display("[TB] stall and illegal opcode");
    readyMode = 1;
    @(posedge clk);
    #2;
    applyStimulus(ADD, 32'h7FFF_FFFF, 32'h1, {5'b01010, 32'h8000_0000}, e1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_hold", {out_valid, in_ready, flags, result},
                  {1'b1, 1'b0, 5'b01010, 32'h8000_0000});
    end
    readyMode = 0;
    @(posedge clk);
    #2;
    applyStimulus(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, {5'b10000, 32'h0}, e1);
    drain();

    $display("[TB] reset during MUL");
    applyStimulus(MUL, 32'h0000_0003, 32'h0000_0005, {5'b00000, 32'd15}, e1);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    expectQ.delete();
    #1;
    checkOutput("abort_in_reset", {out_valid, in_ready}, {1'b0, 1'b1});
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_abort", in_ready, 1);
    validSeen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) validSeen++;
    end
    checkOutput("no_result_after_abort", validSeen, 0);
    @(posedge clk);
    #2;

    $display("[TB] random traffic");
    readyMode = 2;
    for (int n = 0; n < 250; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = pickOperand();
      b  = pickOperand();
      applyStimulus(op, a, b, refModel(op, a, b), e1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    readyMode = 0;
    drain();
    checkOutput("scoreboard_empty", expectQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
